uart_tx_arbiter: RTL and testbench

//  Multiplexes game-side message bytes onto the single UART transmit FIFO write port (w_data/wr_uart).

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_arbiter_pkg                                                     |
// | Shared opcode constants and the arbiter state type.                     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package uart_tx_arbiter_pkg;

  localparam int OPCODE_W = 3;
  localparam logic [OPCODE_W-1:0] OP_NONE = 3'b000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_HOLD  = 2'd2
  } arb_state;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rr_picker                                                               |
// | First set request at or after the pointer, wrapping modulo N.           |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_sel,
  output logic             o_any_valid
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_sel       = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N);
      if (!o_any_valid && i_req[w_idx]) begin
        o_sel       = w_idx;
        o_any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_arbiter                                                         |
// | Round-robin mux of change-driven / periodically refreshed source bytes  |
// | onto the UART TX FIFO write port.                                       |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_SRC          = 4,
  parameter int DATA_W         = 8,
  parameter int REFRESH_CYCLES = 650_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    tx_full,
  output logic [DATA_W-1:0]       w_data,
  output logic                    wr_uart,
  output logic [N_SRC-1:0]        pending
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state          r_state;
  logic [PTR_W-1:0]  r_rr;
  logic [DATA_W-1:0] r_last [N_SRC];

  logic [PTR_W-1:0]  w_sel;
  logic              w_any;
  logic              w_take;
  logic              w_wrap;
  logic [N_SRC-1:0]  w_set;
  logic [N_SRC-1:0]  w_hit;
  logic [DATA_W-1:0] w_sel_data;

  rr_picker #(
    .N     (N_SRC),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .i_req       (pending),
    .i_ptr       (r_rr),
    .o_sel       (w_sel),
    .o_any_valid (w_any)
  );

  assign w_take     = (r_state == ARB_IDLE) && w_any && !tx_full;
  assign w_sel_data = src_data[int'(w_sel)*DATA_W +: DATA_W];

  // The source being taken compares against the value it is about to latch,
  // so a byte already in flight does not immediately re-arm itself.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [DATA_W-1:0] w_byte;
    logic              w_live;

    assign w_byte   = src_data[i*DATA_W +: DATA_W];
    assign w_live   = w_byte[OPCODE_W-1:0] != OP_NONE;
    assign w_hit[i] = w_take && (w_sel == PTR_W'(i));
    assign w_set[i] = w_live && (((w_byte != r_last[i]) && !w_hit[i]) || w_wrap);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_last[i] <= '0;
      end else if (w_hit[i]) begin
        r_last[i] <= w_byte;
      end
    end
  end

  if (REFRESH_CYCLES > 0) begin : g_refresh
    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    logic [TMR_W-1:0] r_timer;

    assign w_wrap = (r_timer == TMR_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_timer <= '0;
      end else if (w_wrap) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end else begin : g_no_refresh
    assign w_wrap = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= w_set | (pending & ~w_hit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_rr    <= '0;
      w_data  <= '0;
      wr_uart <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          wr_uart <= 1'b0;
          if (w_take) begin
            w_data  <= w_sel_data;
            r_rr    <= (w_sel == PTR_W'(N_SRC - 1)) ? '0 : w_sel + 1'b1;
            r_state <= ARB_WRITE;
          end
        end
        ARB_WRITE: begin
          wr_uart <= 1'b1;
          r_state <= ARB_HOLD;
        end
        ARB_HOLD: begin
          wr_uart <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: begin
          wr_uart <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                      |
// | Directed scenarios plus random traffic against a behavioural model.     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int R  = 100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] src_data = '0;
  logic            tx_full = 1'b0;
  logic [DW-1:0]   w_data;
  logic            wr_uart;
  logic [N-1:0]    pending;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] wlog_d [$];
  int         wlog_t [$];

  uart_tx_arbiter #(
    .N_SRC          (N),
    .DATA_W         (DW),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .tx_full  (tx_full),
    .w_data   (w_data),
    .wr_uart  (wr_uart),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: pending flags, last sent bytes, a rotating pointer and
  // a cooldown counting the two busy cycles after each selection.
  logic [7:0] m_last [N];
  bit         m_pend [N];
  int         m_rr, m_cool, m_timer;
  bit         m_take_d, m_wr;
  logic [7:0] m_wdata;

  always @(posedge clk or posedge rst) begin
    bit take, wrap, hit, live;
    int sel, j;
    logic [7:0] s [N];
    bit np [N];
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_last[i] = 8'h00; m_pend[i] = 0; end
      m_rr = 0; m_cool = 0; m_timer = 0; m_take_d = 0; m_wr = 0; m_wdata = 8'h00;
    end else begin
      for (int i = 0; i < N; i++) s[i] = src_data[i*DW +: DW];
      wrap    = (m_timer == R - 1);
      m_timer = wrap ? 0 : m_timer + 1;
      take = 0; sel = 0;
      if (m_cool == 0 && !tx_full) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!take && m_pend[j]) begin take = 1; sel = j; end
        end
      end
      for (int i = 0; i < N; i++) begin
        hit   = take && (sel == i);
        live  = (s[i] % 8) != 0;
        np[i] = (m_pend[i] && !hit) || (live && s[i] != m_last[i] && !hit) || (live && wrap);
      end
      m_wr     = m_take_d;
      m_take_d = take;
      if (take) begin
        m_wdata     = s[sel];
        m_last[sel] = s[sel];
        m_rr        = (sel + 1) % N;
        m_cool      = 2;
      end else if (m_cool > 0) begin
        m_cool = m_cool - 1;
      end
      for (int i = 0; i < N; i++) m_pend[i] = np[i];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [N-1:0] mp;
    if (!rst) begin
      for (int i = 0; i < N; i++) mp[i] = m_pend[i];
      check_eq("model_wr", 32'(wr_uart), 32'(m_wr));
      check_eq("model_wdata", 32'(w_data), 32'(m_wdata));
      check_eq("model_pending", 32'(pending), 32'(mp));
      if (wr_uart) begin
        wlog_d.push_back(w_data);
        wlog_t.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input int idx, input logic [7:0] v);
    src_data[idx*DW +: DW] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; src_data = '0; tx_full = 1'b0;
    tick(2);
    rst = 1'b0;
    wlog_d.delete(); wlog_t.delete();
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);
    check_eq("reset_wr", 32'(wr_uart), 32'h0);
    check_eq("reset_wdata", 32'(w_data), 32'h0);
    check_eq("reset_pending", 32'(pending), 32'h0);

    // Single change on source 0.
    do_reset();
    set_src(0, 8'h29);
    tick(2);
    check_eq("t1_wr_early", 32'(wr_uart), 32'h0);
    tick(1);
    check_eq("t1_wr_lat3", 32'(wr_uart), 32'h1);
    check_eq("t1_wdata", 32'(w_data), 32'h29);
    tick(20);
    check_eq("t1_count", 32'(wlog_d.size()), 32'd1);

    // All four change together: strict rotation, 3 cycles apart.
    do_reset();
    set_src(0, 8'h11); set_src(1, 8'h12); set_src(2, 8'h13); set_src(3, 8'h14);
    tick(20);
    check_eq("t2_count", 32'(wlog_d.size()), 32'd4);
    if (wlog_d.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq("t2_order", 32'(wlog_d[i]), 32'(8'h11 + i));
      for (int i = 1; i < 4; i++) check_eq("t2_spacing", 32'(wlog_t[i] - wlog_t[i-1]), 32'd3);
    end
    check_eq("t2_pending_clear", 32'(pending), 32'h0);

    // Back-pressure with coalescing.
    do_reset();
    tx_full = 1'b1;
    set_src(1, 8'h0A); tick(2);
    set_src(1, 8'h12); tick(2);
    set_src(1, 8'h1A); tick(5);
    check_eq("t3_none_while_full", 32'(wlog_d.size()), 32'd0);
    check_eq("t3_pending_held", 32'(pending), 32'h2);
    tx_full = 1'b0;
    tick(10);
    check_eq("t3_count", 32'(wlog_d.size()), 32'd1);
    if (wlog_d.size() == 1) check_eq("t3_latest", 32'(wlog_d[0]), 32'h1A);

    // Periodic refresh of a static source.
    do_reset();
    set_src(2, 8'h43);
    tick(250);
    check_eq("t4_count", 32'(wlog_d.size()), 32'd3);
    if (wlog_d.size() == 3) begin
      for (int i = 0; i < 3; i++) check_eq("t4_data", 32'(wlog_d[i]), 32'h43);
      check_eq("t4_period", 32'(wlog_t[2] - wlog_t[1]), 32'd100);
    end

    // Asynchronous reset while a write is being set up.
    do_reset();
    set_src(0, 8'h29); set_src(1, 8'h12);
    tick(2);
    check_eq("t5_pre_wdata", 32'(w_data), 32'h29);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_async_wr", 32'(wr_uart), 32'h0);
    check_eq("t5_async_wdata", 32'(w_data), 32'h0);
    check_eq("t5_async_pending", 32'(pending), 32'h0);
    wlog_d.delete(); wlog_t.delete();
    @(negedge clk);
    rst = 1'b0;
    tick(20);
    check_eq("t5_count", 32'(wlog_d.size()), 32'd2);
    if (wlog_d.size() == 2) begin
      check_eq("t5_first", 32'(wlog_d[0]), 32'h29);
      check_eq("t5_second", 32'(wlog_d[1]), 32'h12);
    end

    // Source changes right after being selected.
    do_reset();
    set_src(3, 8'h07);
    tick(1);
    check_eq("t6_pending", 32'(pending), 32'h8);
    tick(1);
    set_src(3, 8'h0F);
    tick(15);
    check_eq("t6_count", 32'(wlog_d.size()), 32'd2);
    if (wlog_d.size() == 2) begin
      check_eq("t6_first", 32'(wlog_d[0]), 32'h07);
      check_eq("t6_second", 32'(wlog_d[1]), 32'h0F);
    end

    // Random traffic; the per-cycle model comparison does the checking.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) < 2) set_src(k, 8'($urandom));
      tx_full = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    tx_full = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
